// File: rtl/bf16_psum_accum.sv
// bf16_psum_accum: sums ACC_LEN BF16 partial dot products in a guard-extended
// signed format and emits one truncated BF16 result per group.
module bf16_psum_accum #(
  parameter int ACC_LEN = 4,
  parameter int GUARD_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);
  localparam int W = 11 + GUARD_W;
  localparam int T = 7 + GUARD_W;
  localparam logic [W-1:0] SAT = {{(W-T-1){1'b0}}, {(T+1){1'b1}}};

  typedef enum logic [2:0] {WAIT, ALIGN, ADD, NORM, OUT} state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, acc_e_q, acc_e_d, e_q, e_d;
  logic signed [W-1:0] acc_m_q, acc_m_d, a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [15:0] in_q, in_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;

  logic [7:0] in_e, diff, e_new;
  logic acc_big, shift_zero;
  logic [W-1:0] in_u, mag, nmag, acc_mag, sat_m;
  logic signed [W-1:0] in_m, acc_shr, in_shr, norm_m;
  logic [7:0] norm_e;
  logic [15:0] out_word;
  int lead, ne;

  assign in_ready  = state_q == WAIT;
  assign busy      = state_q != WAIT;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    in_e = in_q[14:7];
    in_u = W'({1'b1, in_q[6:0]}) << GUARD_W;
    in_m = (in_e == 8'd0) ? '0 : (in_q[15] ? -in_u : in_u);
    acc_big = acc_e_q >= in_e;
    diff = acc_big ? acc_e_q - in_e : in_e - acc_e_q;
    e_new = acc_big ? acc_e_q : in_e;
    shift_zero = int'(diff) >= W - 1;
    acc_shr = acc_m_q >>> diff;
    in_shr = in_m >>> diff;
    mag = sum_q[W-1] ? -sum_q : sum_q;
    lead = 0;
    for (int i = 0; i < W; i++) if (mag[i]) lead = i;
    nmag = (lead >= T) ? mag >> (lead - T) : mag << (T - lead);
    ne = int'(e_q) + lead - T;
    sat_m = sum_q[W-1] ? -SAT : SAT;
    norm_m = (sum_q == '0 || ne <= 0) ? '0 :
             (ne >= 255) ? sat_m : (sum_q[W-1] ? -nmag : nmag);
    norm_e = (sum_q == '0 || ne <= 0) ? 8'd0 : (ne >= 255) ? 8'd254 : 8'(ne);
    acc_mag = acc_m_q[W-1] ? -acc_m_q : acc_m_q;
    out_word = (acc_m_q == '0) ? 16'h0000 :
               {acc_m_q[W-1], acc_e_q, acc_mag[6+GUARD_W -: 7]};
    state_d = state_q;
    cnt_d = cnt_q;
    acc_m_d = acc_m_q;
    acc_e_d = acc_e_q;
    a_d = a_q;
    b_d = b_q;
    e_d = e_q;
    sum_d = sum_q;
    in_d = in_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    case (state_q)
      WAIT: if (in_valid) begin
        in_d = in_data;
        state_d = ALIGN;
      end
      ALIGN: begin
        a_d = acc_big ? acc_m_q : (shift_zero ? '0 : acc_shr);
        b_d = acc_big ? (shift_zero ? '0 : in_shr) : in_m;
        e_d = e_new;
        state_d = ADD;
      end
      ADD: begin
        sum_d = a_q + b_q;
        state_d = NORM;
      end
      NORM: begin
        acc_m_d = norm_m;
        acc_e_d = norm_e;
        cnt_d = cnt_q + 8'd1;
        state_d = (int'(cnt_q) + 1 >= ACC_LEN) ? OUT : WAIT;
      end
      OUT: begin
        out_valid_d = !(out_valid_q && out_ready);
        out_data_d = out_word;
        if (out_valid_q && out_ready) begin
          state_d = WAIT;
          cnt_d = '0;
          acc_m_d = '0;
          acc_e_d = '0;
        end
      end
      default: state_d = WAIT;
    endcase
    if (clear) begin
      state_d = WAIT;
      cnt_d = '0;
      acc_m_d = '0;
      acc_e_d = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      cnt_q <= '0;
      acc_m_q <= '0;
      acc_e_q <= '0;
      a_q <= '0;
      b_q <= '0;
      e_q <= '0;
      sum_q <= '0;
      in_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_m_q <= acc_m_d;
      acc_e_q <= acc_e_d;
      a_q <= a_d;
      b_q <= b_d;
      e_q <= e_d;
      sum_q <= sum_d;
      in_q <= in_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule
